ex_stage: RTL

Execute stage of the 5-stage MIPS pipeline. Sits between the ID/EX register and the memory stage, and drives the EX/MEM pipeline register that the memory stage consumes. Contains the 32-bit ALU and an iterative unsigned multiply/divide unit with HI/LO registers. Interlocks the upstream pipeline while a HI/LO result is pending.

---
 rtl/ex_stage_if.sv | 38 +++
 rtl/ex_stage.sv | 119 +++++++++++
 2 files changed

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX operand+control bundle into the execute stage and EX/MEM bundle out, with pstop/stall/busy/ovf status; master = upstream driver, slave = ex_stage
interface ex_stage_if;
  logic        pstop_i;
  logic [31:0] ID_EX_A;
  logic [31:0] ID_EX_B;
  logic [31:0] ID_EX_imm;
  logic        ID_EX_alu_src;
  logic [3:0]  ID_EX_alu_op;
  logic [4:0]  ID_EX_shamt;
  logic [1:0]  ID_EX_md_op;
  logic [4:0]  ID_EX_dst_reg;
  logic        ID_EX_mem_read;
  logic        ID_EX_mem_write;
  logic        ID_EX_reg_write;
  logic        ID_EX_mem_to_reg;
  logic        stall_o;
  logic        md_busy_o;
  logic        ovf_o;
  logic [31:0] EX_MEM_alu_result;
  logic [31:0] EX_MEM_B;
  logic [4:0]  EX_MEM_dst_reg;
  logic        EX_MEM_mem_read;
  logic        EX_MEM_mem_write;
  logic        EX_MEM_reg_write;
  logic        EX_MEM_mem_to_reg;
  modport master (
    output pstop_i, ID_EX_A, ID_EX_B, ID_EX_imm, ID_EX_alu_src, ID_EX_alu_op, ID_EX_shamt, ID_EX_md_op,
           ID_EX_dst_reg, ID_EX_mem_read, ID_EX_mem_write, ID_EX_reg_write, ID_EX_mem_to_reg,
    input  stall_o, md_busy_o, ovf_o, EX_MEM_alu_result, EX_MEM_B, EX_MEM_dst_reg,
           EX_MEM_mem_read, EX_MEM_mem_write, EX_MEM_reg_write, EX_MEM_mem_to_reg
  );
  modport slave (
    input  pstop_i, ID_EX_A, ID_EX_B, ID_EX_imm, ID_EX_alu_src, ID_EX_alu_op, ID_EX_shamt, ID_EX_md_op,
           ID_EX_dst_reg, ID_EX_mem_read, ID_EX_mem_write, ID_EX_reg_write, ID_EX_mem_to_reg,
    output stall_o, md_busy_o, ovf_o, EX_MEM_alu_result, EX_MEM_B, EX_MEM_dst_reg,
           EX_MEM_mem_read, EX_MEM_mem_write, EX_MEM_reg_write, EX_MEM_mem_to_reg
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage (ALU, iterative MULTU/DIVU with HI/LO, interlock, EX/MEM register); ports clk, rst, bus (ex_stage_if.slave); EX_OVF_EXC_EN enables signed ADD/SUB overflow trap
module ex_stage #(
  parameter int          MD_STEPS = 32,
  parameter logic [31:0] HILO_RST = 32'h0
) (
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave bus
);
  localparam int CW = $clog2(MD_STEPS + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [63:0]   acc;
  logic [31:0]   opnd;
  logic [31:0]   hi;
  logic [31:0]   lo;
  logic          div;
  logic [31:0]   op2;
  logic [31:0]   res;
  logic [32:0]   sum;
  logic [32:0]   r;
  logic [32:0]   diff;
  logic          ge;
  logic [63:0]   nxt;
  logic          issue;
  logic          bubble;
  logic          ovf;
  assign op2 = bus.ID_EX_alu_src ? bus.ID_EX_imm : bus.ID_EX_B;
  always_comb begin
    res = '0;
    case (bus.ID_EX_alu_op)
      4'd0:  res = bus.ID_EX_A + op2;
      4'd1:  res = bus.ID_EX_A - op2;
      4'd2:  res = bus.ID_EX_A & op2;
      4'd3:  res = bus.ID_EX_A | op2;
      4'd4:  res = bus.ID_EX_A ^ op2;
      4'd5:  res = ~(bus.ID_EX_A | op2);
      4'd6:  res = {31'b0, $signed(bus.ID_EX_A) < $signed(op2)};
      4'd7:  res = {31'b0, bus.ID_EX_A < op2};
      4'd8:  res = bus.ID_EX_B << bus.ID_EX_shamt;
      4'd9:  res = bus.ID_EX_B >> bus.ID_EX_shamt;
      4'd10: res = $signed(bus.ID_EX_B) >>> bus.ID_EX_shamt;
      4'd11: res = {bus.ID_EX_imm[15:0], 16'b0};
      4'd12: res = hi;
      4'd13: res = lo;
      default: res = '0;
    endcase
  end
  // acc holds {HI,LO} while multiplying and {remainder,quotient} while dividing
  assign sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign r    = acc[63:31];
  assign diff = r - {1'b0, opnd};
  assign ge   = r >= {1'b0, opnd};
  assign nxt  = div ? {ge ? diff[31:0] : r[31:0], acc[30:0], ge} : {sum, acc[31:1]};
  assign issue = state == IDLE && (bus.ID_EX_md_op == 2'b01 || bus.ID_EX_md_op == 2'b10) && !bus.pstop_i;
  assign bus.md_busy_o = state == BUSY;
  assign bus.stall_o = bus.md_busy_o && !bus.pstop_i &&
                       (bus.ID_EX_alu_op == 4'd12 || bus.ID_EX_alu_op == 4'd13 || bus.ID_EX_md_op != 2'b00);
  assign bubble = issue || bus.stall_o;
`ifdef EX_OVF_EXC_EN
  logic ovf_q;
  assign ovf = !bubble && bus.ID_EX_alu_op[3:1] == 3'b000 && res[31] != bus.ID_EX_A[31] &&
               ((bus.ID_EX_alu_op[0] ? ~op2[31] : op2[31]) == bus.ID_EX_A[31]);
  assign bus.ovf_o = ovf_q;
  always_ff @(posedge clk)
    if (rst) ovf_q <= 1'b0;
    else if (!bus.pstop_i) ovf_q <= ovf;
`else
  assign ovf = 1'b0;
  assign bus.ovf_o = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.EX_MEM_alu_result <= '0;
      bus.EX_MEM_B          <= '0;
      bus.EX_MEM_dst_reg    <= '0;
      bus.EX_MEM_mem_read   <= 1'b0;
      bus.EX_MEM_mem_write  <= 1'b0;
      bus.EX_MEM_reg_write  <= 1'b0;
      bus.EX_MEM_mem_to_reg <= 1'b0;
    end else if (!bus.pstop_i) begin
      bus.EX_MEM_alu_result <= res;
      bus.EX_MEM_B          <= bus.ID_EX_B;
      bus.EX_MEM_dst_reg    <= bus.ID_EX_dst_reg;
      bus.EX_MEM_mem_read   <= bus.ID_EX_mem_read && !bubble;
      bus.EX_MEM_mem_write  <= bus.ID_EX_mem_write && !bubble;
      bus.EX_MEM_reg_write  <= bus.ID_EX_reg_write && !bubble && !ovf;
      bus.EX_MEM_mem_to_reg <= bus.ID_EX_mem_to_reg && !bubble;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      opnd  <= '0;
      div   <= 1'b0;
      hi    <= HILO_RST;
      lo    <= HILO_RST;
    end else if (!bus.pstop_i) begin
      if (issue) begin
        state <= BUSY;
        cnt   <= CW'(MD_STEPS);
        acc   <= {32'b0, bus.ID_EX_A};
        opnd  <= bus.ID_EX_B;
        div   <= bus.ID_EX_md_op == 2'b10;
      end else if (state == BUSY) begin
        acc <= nxt;
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          hi    <= nxt[63:32];
          lo    <= nxt[31:0];
          state <= IDLE;
        end
      end
    end
  end
endmodule
